logic_operand_sequencer: RTL and testbench

LOGIC_OPERAND_SEQUENCER -- requirements
Module: logic_operand_sequencer

---
 rtl/logic_seq_pkg.sv | 30 +++
 rtl/logic_operand_sequencer.sv | 148 ++++++++++++++
 tb/tb_logic_operand_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_seq_pkg.sv
// rtl/logic_seq_pkg.sv - shared types and constants for the logic operand sequencer
//
// Purpose: FSM state encoding, opcode values and frame length used by
//          logic_operand_sequencer and its environment.
// Ports:   none (package).

package logic_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_A_LO = 3'd1,
      ST_A_HI = 3'd2,
      ST_B_LO = 3'd3,
      ST_B_HI = 3'd4,
      ST_EXEC = 3'd5,
      ST_CAPT = 3'd6,
      ST_OUT  = 3'd7
   } state_t;

   localparam logic [7:0] OP_OR     = 8'h00;
   localparam logic [7:0] OP_NOR    = 8'h01;
   localparam int         FRAME_LEN = 5;

   // True for the states that accept a frame byte.
   function automatic logic is_loading(input state_t s);
      return (s == ST_IDLE) || (s == ST_A_LO) || (s == ST_A_HI) ||
             (s == ST_B_LO) || (s == ST_B_HI);
   endfunction

endpackage

// File: rtl/logic_operand_sequencer.sv
// rtl/logic_operand_sequencer.sv - byte-framed operand loader and OR/NOR result sequencer
//
// Purpose: collects a 5-byte frame (opcode, A lo/hi, B lo/hi), drives the
//          operands to external OR/NOR units, waits for the registered OR
//          unit, captures the selected result and holds it until accepted.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     command/operand byte
//   in_valid    in_data valid
//   in_ready    byte accepted when in_valid & in_ready
//   a, b        operands to the OR/NOR units
//   or_result   registered OR unit output (one-clock latency)
//   nor_result  combinational NOR unit output
//   res_data    captured result
//   res_valid   res_data valid, held until accepted
//   res_ready   consumer accepts when res_valid & res_ready
//   err         high with res_data when the opcode was illegal
//   busy        high whenever the FSM is not in IDLE

module logic_operand_sequencer
   import logic_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] a,
   output logic [15:0] b,
   input  logic [15:0] or_result,
   input  logic [15:0] nor_result,
   output logic [15:0] res_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        err,
   output logic        busy
);

   state_t      r_state;
   logic [7:0]  r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [15:0] r_res_data;
   logic        r_res_valid;
   logic        r_err;
   logic        r_busy;
   logic        r_in_ready;

   logic        w_in_xfer;
   logic        w_res_xfer;

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_res_xfer = r_res_valid & res_ready;

   // Single FSM; every output is a register updated alongside the state.
   // in_ready is registered so it is low throughout reset and first rises
   // on the edge after release, and so it only reopens one cycle after a
   // result transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= 8'h00;
         r_a         <= 16'h0000;
         r_b         <= 16'h0000;
         r_res_data  <= 16'h0000;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_in_xfer) begin
                  r_op    <= in_data;
                  r_busy  <= 1'b1;
                  r_state <= ST_A_LO;
               end
            end
            ST_A_LO: begin
               if (w_in_xfer) begin
                  r_a[7:0] <= in_data;
                  r_state  <= ST_A_HI;
               end
            end
            ST_A_HI: begin
               if (w_in_xfer) begin
                  r_a[15:8] <= in_data;
                  r_state   <= ST_B_LO;
               end
            end
            ST_B_LO: begin
               if (w_in_xfer) begin
                  r_b[7:0] <= in_data;
                  r_state  <= ST_B_HI;
               end
            end
            ST_B_HI: begin
               if (w_in_xfer) begin
                  r_b[15:8]  <= in_data;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_EXEC;
               end
            end
            // One idle cycle so the registered OR unit sees the final operands;
            // taken for every opcode to keep result latency uniform.
            ST_EXEC: begin
               r_state <= ST_CAPT;
            end
            ST_CAPT: begin
               if (r_op == OP_OR) begin
                  r_res_data <= or_result;
                  r_err      <= 1'b0;
               end else if (r_op == OP_NOR) begin
                  r_res_data <= nor_result;
                  r_err      <= 1'b0;
               end else begin
                  r_res_data <= 16'h0000;
                  r_err      <= 1'b1;
               end
               r_res_valid <= 1'b1;
               r_state     <= ST_OUT;
            end
            ST_OUT: begin
               if (w_res_xfer) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign a         = r_a;
   assign b         = r_b;
   assign res_data  = r_res_data;
   assign res_valid = r_res_valid;
   assign err       = r_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_logic_operand_sequencer.sv
// tb/tb_logic_operand_sequencer.sv - self-checking bench for logic_operand_sequencer

module tb_logic_operand_sequencer;
   import logic_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] or_result;
   logic [15:0] nor_result;
   logic [15:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic        err;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   logic_operand_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .or_result  (or_result),
      .nor_result (nor_result),
      .res_data   (res_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .err        (err),
      .busy       (busy)
   );

   // External units: OR registered (one-clock latency), NOR combinational.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) or_result <= 16'h0000;
      else        or_result <= a | b;
   end
   assign nor_result = ~(a | b);

   // Frame-level reference: {err, result} for a complete frame.
   function automatic logic [16:0] model(input logic [7:0] op, input logic [15:0] x,
                                         input logic [15:0] y);
      if (op == 8'h00)      return {1'b0, x | y};
      else if (op == 8'h01) return {1'b0, ~(x | y)};
      else                  return {1'b1, 16'h0000};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge after the transferring edge.
   task automatic send_byte(input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [15:0] x,
                             input logic [15:0] y, input int max_gap);
      logic [7:0] by [FRAME_LEN];
      by[0] = op;      by[1] = x[7:0]; by[2] = x[15:8];
      by[3] = y[7:0];  by[4] = y[15:8];
      for (int i = 0; i < FRAME_LEN; i++) begin
         send_byte(by[i]);
         if (i < FRAME_LEN - 1 && max_gap > 0)
            repeat ($urandom_range(1, max_gap)) @(negedge clk);
      end
   endtask

   // Starts at the negedge after the last byte was accepted (EXEC cycle).
   task automatic collect(input logic [15:0] exp_res, input logic exp_err, input int hold);
      res_ready = 1'b0;
      chk("lat1_valid", res_valid, 0);
      chk("lat1_in_ready", in_ready, 0);
      chk("lat1_busy", busy, 1);
      @(negedge clk);
      chk("lat2_valid", res_valid, 0);
      @(negedge clk);
      chk("lat3_valid", res_valid, 1);
      chk("res_data", res_data, exp_res);
      chk("err", err, exp_err);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", res_valid, 1);
         chk("hold_data", res_data, exp_res);
         chk("hold_in_ready", in_ready, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("xfer_valid_drop", res_valid, 0);
      chk("xfer_in_ready", in_ready, 1);
      chk("xfer_busy", busy, 0);
   endtask

   task automatic run_frame(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                            input int max_gap, input int hold,
                            input logic [15:0] exp_res, input logic exp_err);
      send_frame(op, x, y, max_gap);
      chk("a_loaded", a, x);
      chk("b_loaded", b, y);
      collect(exp_res, exp_err, hold);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      chk("rst_in_ready_held", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_before_edge", in_ready, 0);
      @(negedge clk);
      chk("rel_in_ready_after_edge", in_ready, 1);
      chk("rel_busy", busy, 0);
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [15:0] x;
      logic [15:0] y;
      int          hold;
      logic [15:0] exp_res;
      logic        exp_err;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [16:0] m;
      logic [7:0]  op;
      logic [15:0] x;
      logic [15:0] y;
      logic        saw_valid;

      tbl[0] = '{8'h00, 16'h1234, 16'hF00F, 10, 16'hF23F, 1'b0};
      tbl[1] = '{8'h01, 16'hFF00, 16'h00FF, 0,  16'h0000, 1'b0};
      tbl[2] = '{8'h02, 16'hAAAA, 16'h5555, 1,  16'h0000, 1'b1};
      tbl[3] = '{8'h01, 16'h0000, 16'h0000, 2,  16'hFFFF, 1'b0};
      tbl[4] = '{8'h00, 16'h0000, 16'h0000, 0,  16'h0000, 1'b0};
      tbl[5] = '{8'hFF, 16'hFFFF, 16'hFFFF, 3,  16'h0000, 1'b1};
      tbl[6] = '{8'h01, 16'h1234, 16'hF00F, 1,  16'h0DC0, 1'b0};

      rst_n     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      res_ready = 1'b0;
      do_reset();

      for (int i = 0; i < 7; i++)
         run_frame(tbl[i].op, tbl[i].x, tbl[i].y, 0, tbl[i].hold,
                   tbl[i].exp_res, tbl[i].exp_err);

      // Gapped input with junk on in_data during the gaps.
      run_frame(8'h00, 16'h00FF, 16'hFF00, 1, 1, 16'hFFFF, 1'b0);

      // Reset after three bytes: partial frame discarded.
      res_ready = 1'b1;
      send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
      res_ready = 1'b0;
      do_reset();
      saw_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (res_valid) saw_valid = 1'b1;
      end
      chk("no_valid_after_midframe_reset", saw_valid, 0);
      run_frame(8'h00, 16'h0001, 16'h0002, 0, 0, 16'h0003, 1'b0);

      // Reset while a result is pending.
      send_frame(8'h01, 16'h0F0F, 16'h0000, 0);
      repeat (2) @(negedge clk);
      chk("pending_valid", res_valid, 1);
      do_reset();
      saw_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (res_valid) saw_valid = 1'b1;
      end
      chk("no_valid_after_result_reset", saw_valid, 0);

      // Randomized frames against the frame-level model; res_ready toggled
      // randomly while bytes are loading must have no effect.
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0:       op = 8'h00;
            1:       op = 8'h01;
            default: op = 8'($urandom);
         endcase
         x = 16'($urandom);
         y = 16'($urandom);
         m = model(op, x, y);
         res_ready = 1'($urandom);
         run_frame(op, x, y, $urandom_range(0, 2), $urandom_range(0, 4), m[15:0], m[16]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
